// File: rtl/apb_master.sv
// APB requester bridge: turns a level-sampled local request into
// SETUP/ACCESS transfers and returns read data and error status.
module apb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  trans_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  wr_rd_i,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [DATA_WIDTH-1:0] prdata,
    output logic                  pselx,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  trans_err_o
);

    // bit0 = select, bit1 = enable, so the bus controls come straight off flops
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b11
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   done;
    logic   load;

    assign done = (state_q == ACCESS) && pready;
    assign load = trans_i && ((state_q == IDLE) || done);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (trans_i) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (pready) state_d = trans_i ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pselx   = state_q[0];
        penable = state_q[1];
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rdata_o     <= '0;
            trans_err_o <= 1'b0;
        end else begin
            if (load) begin
                paddr  <= addr_i;
                pwrite <= wr_rd_i;
                pwdata <= wdata_i;
            end
            if (done && !pwrite) begin
                rdata_o <= prdata;
            end
            trans_err_o <= done && pslverr;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Randomised scoreboard bench for apb_master with a behavioural
// APB completer and a transfer-level reference model.
module tb_apb_master;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        wr;
        logic        err;
        int          waits;
    } txn_t;

    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic        trans_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        wr_rd_i = 1'b0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;
    logic [31:0] prdata = '0;
    logic        pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] rdata_o;
    logic        trans_err_o;

    apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .pclk        (pclk),
        .preset_n    (preset_n),
        .trans_i     (trans_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .wr_rd_i     (wr_rd_i),
        .pready      (pready),
        .pslverr     (pslverr),
        .prdata      (prdata),
        .pselx       (pselx),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .rdata_o     (rdata_o),
        .trans_err_o (trans_err_o)
    );

    always #5 pclk = ~pclk;

    txn_t exp_q[$];
    txn_t cpl_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_issued = 0;
    int   n_done = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // APB completer: wait states, read data and error come from the
    // transaction descriptor; everything else it drives is junk.
    initial begin
        txn_t ccur;
        int   ccnt;
        ccur = '{default: '0};
        ccnt = 0;
        forever begin
            @(negedge pclk);
            if (pselx && !penable) begin
                if (cpl_q.size() > 0) ccur = cpl_q.pop_front();
                ccnt = 0;
            end
            if (pselx && penable) begin
                if (ccnt < ccur.waits) begin
                    pready  = 1'b0;
                    pslverr = 1'($urandom);
                    prdata  = $urandom;
                    ccnt++;
                end else begin
                    pready  = 1'b1;
                    pslverr = ccur.err;
                    prdata  = ccur.wr ? $urandom : ccur.rdata;
                end
            end else begin
                pready  = 1'($urandom);
                pslverr = 1'($urandom);
                prdata  = $urandom;
            end
        end
    end

    // Monitor: follows the bus at transfer level and scores it.
    initial begin
        txn_t        cur;
        bit          have_cur;
        int          acc_cnt;
        logic [31:0] model_rdata;
        logic        pre_sel, pre_en, pre_rdy, done;
        cur = '{default: '0};
        have_cur = 1'b0;
        acc_cnt = 0;
        model_rdata = '0;
        forever begin
            @(negedge pclk);
            #1;
            pre_sel = pselx;
            pre_en  = penable;
            pre_rdy = pready;
            @(posedge pclk);
            #1;
            if (!mon_en) continue;
            done = pre_sel && pre_en && pre_rdy;
            if (pre_sel && pre_en) acc_cnt++;
            if (done) begin
                check("trans_err", 32'(trans_err_o), 32'(cur.err));
                if (!cur.wr) model_rdata = cur.rdata;
                check("rdata_done", rdata_o, model_rdata);
                check("access_cycles", acc_cnt, cur.waits + 1);
                n_done++;
            end else begin
                check("trans_err_quiet", 32'(trans_err_o), 32'd0);
                check("rdata_hold", rdata_o, model_rdata);
            end
            if (pselx && !penable) begin
                check("setup_entry", 32'(!pre_sel || done), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_setup", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1'b1;
                    acc_cnt = 0;
                    check("setup_paddr", paddr, cur.addr);
                    check("setup_pwrite", 32'(pwrite), 32'(cur.wr));
                    check("setup_pwdata", pwdata, cur.wdata);
                end
            end else begin
                if (pselx && penable) begin
                    check("access_entry", 32'(pre_sel && !done), 32'd1);
                end else begin
                    check("idle_entry", 32'(!pre_sel || done), 32'd1);
                    check("idle_penable", 32'(penable), 32'd0);
                end
                if (have_cur) begin
                    check("paddr_stable", paddr, cur.addr);
                    check("pwrite_stable", 32'(pwrite), 32'(cur.wr));
                    check("pwdata_stable", pwdata, cur.wdata);
                end
            end
        end
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            trans_i = 1'b0;
            addr_i  = $urandom;
            wdata_i = $urandom;
            wr_rd_i = 1'($urandom);
        end
    endtask

    task automatic issue(input txn_t t, input int gap, input bit score);
        bit taken;
        idle_cycles(gap);
        if (score) begin
            exp_q.push_back(t);
            n_issued++;
        end
        cpl_q.push_back(t);
        @(negedge pclk);
        trans_i = 1'b1;
        addr_i  = t.addr;
        wdata_i = t.wdata;
        wr_rd_i = t.wr;
        taken = 1'b0;
        for (int c = 0; c < 200 && !taken; c++) begin
            @(posedge pclk);
            #1;
            taken = pselx && !penable;
        end
        if (!taken) check("request_timeout", 32'd0, 32'd1);
    endtask

    function automatic txn_t mk(input logic [31:0] a, input logic w,
                                input logic [31:0] rd, input logic e,
                                input int ws);
        txn_t t;
        t.addr  = a;
        t.wdata = $urandom;
        t.rdata = rd;
        t.wr    = w;
        t.err   = e;
        t.waits = ws;
        return t;
    endfunction

    initial begin
        txn_t t;
        bit   ok;

        for (int i = 0; i < 2; i++) begin
            @(negedge pclk);
            trans_i = 1'($urandom);
            addr_i  = $urandom;
            wdata_i = $urandom;
            wr_rd_i = 1'($urandom);
            #1;
            check("rst_bus", {penable, pselx, pwrite, trans_err_o}, 32'd0);
            check("rst_paddr", paddr, 32'd0);
            check("rst_pwdata", pwdata, 32'd0);
            check("rst_rdata", rdata_o, 32'd0);
        end
        @(negedge pclk);
        trans_i  = 1'b0;
        preset_n = 1'b1;
        mon_en   = 1'b1;

        t = mk(32'h10, 1'b1, 32'h0, 1'b0, 0);
        t.wdata = 32'hA5A5_0001;
        issue(t, 1, 1'b1);
        issue(mk(32'h20, 1'b0, 32'hDEAD_BEEF, 1'b0, 2), 2, 1'b1);
        issue(mk(32'h30, 1'b1, 32'h0, 1'b1, 0), 4, 1'b1);
        issue(mk($urandom, 1'b0, $urandom, 1'b0, 0), 4, 1'b1);
        issue(mk(32'h40, 1'b1, 32'h0, 1'b0, 0), 4, 1'b1);
        issue(mk(32'h44, 1'b0, 32'h1234_5678, 1'b0, 0), 0, 1'b1);
        idle_cycles(8);

        for (int i = 0; i < 300; i++) begin
            int gap;
            int ws;
            gap = ($urandom_range(0, 9) < 4) ? 0 : $urandom_range(1, 3);
            ws  = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2)
                                              : $urandom_range(3, 6);
            issue(mk($urandom, 1'($urandom), $urandom,
                     ($urandom_range(0, 3) == 0), ws), gap, 1'b1);
        end

        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            idle_cycles(1);
            ok = (n_done == n_issued);
        end
        idle_cycles(4);
        check("all_completed", n_done, n_issued);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        mon_en = 1'b0;
        issue(mk(32'h55, 1'b1, 32'h0, 1'b1, 20), 2, 1'b0);
        @(posedge pclk);
        #1;
        check("pre_abort_access", {penable, pselx}, 32'd3);
        @(negedge pclk);
        #2;
        preset_n = 1'b0;
        #1;
        check("abort_bus", {penable, pselx, pwrite, trans_err_o}, 32'd0);
        check("abort_paddr", paddr, 32'd0);
        check("abort_rdata", rdata_o, 32'd0);
        @(posedge pclk);
        #1;
        check("abort_no_err", {trans_err_o, penable, pselx}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
